// File: rtl/ahb_arb_pkg.sv
// rtl/ahb_arb_pkg.sv - shared types and constants for the 2-master AHB arbiter
package ahb_arb_pkg;

   typedef enum logic [1:0] {
      PARK   = 2'd0,
      OWNED  = 2'd1,
      LOCKED = 2'd2
   } arb_state_t;

   typedef logic mst_idx_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   function automatic logic xfer_active(input logic [1:0] t);
      case (t)
         HTRANS_IDLE, HTRANS_BUSY:  return 1'b0;
         HTRANS_NONSEQ, HTRANS_SEQ: return 1'b1;
         default:                   return 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] onehot(input mst_idx_t m);
      return m ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/ahb_arb_pick.sv
// rtl/ahb_arb_pick.sv - combinational winner select for the 2-master arbiter
module ahb_arb_pick
   import ahb_arb_pkg::*;
#(
   parameter int RR_MODE        = 1,
   parameter int DEFAULT_MASTER = 0
) (
   input  logic [1:0] i_busreq,
   input  mst_idx_t   i_owner,
   input  mst_idx_t   i_last_owner,
   input  logic       i_owned,
   input  logic       i_hold_expired,
   output mst_idx_t   o_winner,
   output logic       o_any_req
);

   localparam mst_idx_t DEF_M = (DEFAULT_MASTER != 0);

   mst_idx_t w_other;

   always_comb begin
      w_other   = ~i_owner;
      o_any_req = |i_busreq;
      o_winner  = DEF_M;
      if (i_busreq == 2'b00)
         o_winner = DEF_M;
      else if (i_owned && i_busreq[i_owner] && !(i_hold_expired && i_busreq[w_other]))
         o_winner = i_owner;
      // Contention from PARK uses the priority rule; an expired owner always yields.
      else if (i_busreq == 2'b11 && !i_owned)
         o_winner = (RR_MODE != 0) ? ~i_last_owner : 1'b0;
      else if (i_busreq == 2'b11)
         o_winner = w_other;
      else
         o_winner = i_busreq[1];
   end

endmodule

// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - 2-master AHB bus arbiter with round-robin, locking and hold limit
module ahb_arbiter
   import ahb_arb_pkg::*;
#(
   parameter int RR_MODE        = 1,
   parameter int MAX_HOLD       = 8,
   parameter int DEFAULT_MASTER = 0
) (
   input  logic       hclk,
   input  logic       hreset,
   input  logic [1:0] hbusreq,
   input  logic [1:0] hlock,
   input  logic [1:0] htrans,
   input  logic       hready,
   output logic [1:0] hgrant,
   output logic       hmaster,
   output logic       hmaster_d,
   output logic       hmastlock
);

   localparam mst_idx_t   DEF_M    = (DEFAULT_MASTER != 0);
   localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

   arb_state_t r_state;
   logic [1:0] r_grant;
   mst_idx_t   r_master;
   mst_idx_t   r_master_d;
   mst_idx_t   r_last_owner;
   logic       r_mastlock;
   logic [7:0] r_hold_cnt;

   logic       w_accept;
   logic       w_lock_keep;
   logic       w_lock_start;
   logic       w_hold_expired;
   logic       w_any_req;
   mst_idx_t   w_winner;

   assign w_accept       = hready && xfer_active(htrans);
   assign w_lock_keep    = (r_state == LOCKED) && hlock[r_master];
   assign w_lock_start   = w_accept && (htrans == HTRANS_NONSEQ) && hlock[r_master];
   assign w_hold_expired = (r_hold_cnt >= HOLD_MAX);

   ahb_arb_pick #(
      .RR_MODE        (RR_MODE),
      .DEFAULT_MASTER (DEFAULT_MASTER)
   ) u_pick (
      .i_busreq       (hbusreq),
      .i_owner        (r_master),
      .i_last_owner   (r_last_owner),
      .i_owned        (r_state != PARK),
      .i_hold_expired (w_hold_expired),
      .o_winner       (w_winner),
      .o_any_req      (w_any_req)
   );

   always_ff @(posedge hclk) begin
      if (hreset) begin
         r_state      <= PARK;
         r_grant      <= onehot(DEF_M);
         r_master     <= DEF_M;
         r_master_d   <= DEF_M;
         r_last_owner <= ~DEF_M;
         r_mastlock   <= 1'b0;
         r_hold_cnt   <= 8'd0;
      end else if (hready) begin
         r_master_d <= r_master;
         // A locked sequence (new or ongoing) freezes ownership and bypasses the hold limit.
         if (w_lock_keep || w_lock_start) begin
            r_state    <= LOCKED;
            r_mastlock <= 1'b1;
            if (w_accept && r_hold_cnt < HOLD_MAX)
               r_hold_cnt <= r_hold_cnt + 8'd1;
         end else begin
            r_mastlock <= 1'b0;
            r_state    <= w_any_req ? OWNED : PARK;
            if (w_winner != r_master) begin
               r_grant      <= onehot(w_winner);
               r_master     <= w_winner;
               r_last_owner <= r_master;
               r_hold_cnt   <= 8'd0;
            end else if (w_accept && r_hold_cnt < HOLD_MAX) begin
               r_hold_cnt <= r_hold_cnt + 8'd1;
            end
         end
      end
   end

   assign hgrant    = r_grant;
   assign hmaster   = r_master;
   assign hmaster_d = r_master_d;
   assign hmastlock = r_mastlock;

endmodule
